cpu_debug_scan_master: RTL and testbench
========================================

Name: cpu_debug_scan_master

Overview:
- Initiator end of the CPU debug slave's virtual-JTAG interface.
- Takes one scan command (IR value plus 38-bit DR word) from a sysclk-domain host or test sequencer.
- Generates the vji_* strobe sequence (tck, tdi, ir_in, uir, cdr, sdr, udr, rti) that the debug slave consumes, and returns the 38-bit word shifted out on tdo.
- Used for on-chip self-debug and as the drive model in simulation, replacing the constant-zero vji tie-offs.

Parameters:
- DR_WIDTH, 38, scan data register length in bits.
- IR_WIDTH, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half-period (legal range 1..255).
- RTI_TCKS, 1, tck periods spent in run-test-idle after each update (legal range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  scan command present.
- cmd_ready  out  1  master idle; command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value for this scan.
- cmd_dr  in  DR_WIDTH  DR word to shift in, LSB first.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  host accepts result.
- rsp_dr  out  DR_WIDTH  word captured from tdo, bit0 = first bit out.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during CDR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  virtual IR presented to slave.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Synchronous active-high reset, taking effect at the next clk edge:
  - state IDLE, cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0.
  - All vji_* outputs 0, including tck low.
- Reset mid-scan abandons the scan immediately; no response is produced.
- Tck generator:
  - Half-period counter runs only while the state is not IDLE or DONE.
  - Each tck period is TCK_HALF clk cycles low followed by TCK_HALF clk cycles high.
  - A new period always starts low.
- All strobes, tdi and ir_in change only at the first clk of a low phase (tck falling edge).
- vji_tdo and vji_ir_out are sampled on the last clk of the low phase, immediately before the rising edge.
- FSM; each non-idle state lasts whole tck periods:
  - IDLE: cmd_ready=1. On accept, latch cmd_ir and cmd_dr into a shift register, clear the bit counter, go to UIR.
  - UIR: 1 tck period. vji_uir=1; vji_ir_in=latched IR, held until the next accept.
  - CDR: 1 period. vji_cdr=1; sample vji_ir_out into rsp_ir_out.
  - SDR: DR_WIDTH periods. vji_sdr=1; vji_tdi=shift[0].
    - Each sample point: tdo goes into capture[bit_cnt]; shift register shifts right.
    - Leave SDR after bit_cnt reaches DR_WIDTH-1.
  - UDR: 1 period. vji_udr=1.
  - RTI: RTI_TCKS periods. vji_rti=1.
  - DONE: tck low, all strobes 0. rsp_valid=1, rsp_dr=capture. Hold until rsp_ready, then go to IDLE on the next clk.
- Only one strobe is high at any time.
- vji_tdi=0 outside SDR.
- cmd_ready=0 from the clk after accept until DONE exits.
- rsp_ready while rsp_valid=0 is ignored.
- cmd_valid while busy is ignored; the command is not queued.
- Latency: accept at edge k gives rsp_valid high from edge k+1+2*TCK_HALF*(3+DR_WIDTH+RTI_TCKS).
  - Defaults: k+169.
- If rsp_ready is high in the DONE cycle, rsp_valid is high for exactly one clk.
- Counters:
  - bit_cnt is 6 bits.
  - Half-period counter is 8 bits and wraps TCK_HALF-1 -> 0.
  - The period counter for RTI counts 0..RTI_TCKS-1.

Test Plan:
- Reset checks:
  - Reset asserted for 3 clk during SDR bit 10: next clk all vji_*=0, cmd_ready=1, rsp_valid never asserts.
  - A subsequent command completes normally.
- Loopback scan: vji_tdo driven from a 38-bit shift register modelled on the slave (load 0x15_A5A5_A5A5 at CDR rising edge, shift on tck rise while sdr), cmd_dr=0x2A_5A5A_5A5A, cmd_ir=2.
  - rsp_dr=0x15_A5A5_A5A5.
  - The model register ends holding 0x2A_5A5A_5A5A.
  - vji_ir_in=2.
- Timing with defaults: accept at cycle 0 gives rsp_valid at cycle 169.
  - Exactly 42 tck rising edges are observed.
  - sdr high for exactly 38 of them.
  - uir, cdr, udr, rti high for 1 edge each.
- Parameter corner TCK_HALF=1, RTI_TCKS=3: tck toggles every clk, rsp_valid at cycle 1+2*44=89, rti high for 3 tck periods.
- Backpressure: rsp_ready held 0 for 20 clk after rsp_valid.
  - rsp_valid and rsp_dr stay stable; cmd_ready stays 0.
  - cmd_valid pulsed during this window is ignored.
  - Release rsp_ready: cmd_ready=1 on the next clk.
- Back-to-back commands: cmd_valid held high with IR 0, then 3.
  - Second accept occurs the clk after the first response handshake.
  - rsp_ir_out reflects vji_ir_out driven as 1, then 2.
  - vji_ir_in changes only at the second UIR falling edge.

Source files
------------

// File: rtl/cpu_debug_scan_master.sv
// -----------------------------------------------------------------------------
// cpu_debug_scan_master
// Initiator side of the CPU debug slave's virtual-JTAG port. It accepts one scan
// command (IR value plus DR word) from a clk-domain host, drives the vji_*
// strobe sequence UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI x RTI_TCKS on a
// generated tck, and returns the DR word shifted out on tdo.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only when idle)
//   cmd_ir, cmd_dr        IR value and DR word (shifted LSB first)
//   rsp_valid/rsp_ready   response handshake
//   rsp_dr                word captured from tdo, bit0 = first bit out
//   rsp_ir_out            vji_ir_out sampled during CDR
//   vji_tck, vji_tdi      generated test clock and serial data to the slave
//   vji_tdo, vji_ir_out   serial data and IR status from the slave
//   vji_ir_in             virtual IR presented to the slave
//   vji_uir..vji_rti      virtual state strobes (at most one high)
// -----------------------------------------------------------------------------
module cpu_debug_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_HALF = 2,
    parameter int unsigned RTI_TCKS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned BIT_CNT_W  = 6;
    localparam int unsigned HALF_CNT_W = 8;
    localparam int unsigned RTI_CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HALF_CNT_W-1:0] half_cnt;
    logic                  phase_hi;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [RTI_CNT_W-1:0]  rti_cnt;
    logic [IR_WIDTH-1:0]   ir_lat;
    logic [DR_WIDTH-1:0]   shift_q;
    logic [DR_WIDTH-1:0]   capture_q;

    logic accept_c;
    logic running_c;
    logic half_end_c;
    logic sample_c;
    logic period_end_c;
    logic fall_c;

    logic                cmd_ready_d;
    logic                rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_dr_d;
    logic [IR_WIDTH-1:0] rsp_ir_out_d;
    logic                tck_d;
    logic                tdi_d;
    logic [IR_WIDTH-1:0] ir_in_d;
    logic                uir_d;
    logic                cdr_d;
    logic                sdr_d;
    logic                udr_d;
    logic                rti_d;

    // Internal tck timeline. Every vji_* pin is registered from it, so the pins
    // lag the internal phase by one clk. The internal first-high cycle is the
    // edge where vji_tck rises, i.e. the end of the last low clk on the pins.
    assign accept_c     = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign running_c    = (state != S_IDLE) && (state != S_DONE);
    assign half_end_c   = (half_cnt == HALF_CNT_W'(TCK_HALF - 1));
    assign sample_c     = running_c && phase_hi && (half_cnt == '0);
    assign period_end_c = running_c && phase_hi && half_end_c;
    assign fall_c       = !phase_hi && (half_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every non-idle state advances only at a period end
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept_c) state_nxt = S_UIR;
            S_UIR:  if (period_end_c) state_nxt = S_CDR;
            S_CDR:  if (period_end_c) state_nxt = S_SDR;
            S_SDR:  if (period_end_c && (bit_cnt == BIT_CNT_W'(DR_WIDTH - 1))) state_nxt = S_UDR;
            S_UDR:  if (period_end_c) state_nxt = S_RTI;
            S_RTI:  if (period_end_c && (rti_cnt == RTI_CNT_W'(RTI_TCKS - 1))) state_nxt = S_DONE;
            S_DONE: if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode (next values of the registered outputs)
    always_comb begin
        cmd_ready_d  = (state_nxt == S_IDLE);
        rsp_valid_d  = (state == S_DONE) && !(rsp_valid && rsp_ready);
        rsp_dr_d     = rsp_dr;
        rsp_ir_out_d = rsp_ir_out;
        tck_d        = running_c && phase_hi;
        tdi_d        = vji_tdi;
        ir_in_d      = vji_ir_in;
        uir_d        = (state == S_UIR);
        cdr_d        = (state == S_CDR);
        sdr_d        = (state == S_SDR);
        udr_d        = (state == S_UDR);
        rti_d        = (state == S_RTI);
        if (state == S_DONE) begin
            rsp_dr_d = capture_q;
        end
        if ((state == S_CDR) && sample_c) begin
            rsp_ir_out_d = vji_ir_out;
        end
        // tdi only moves together with the tck falling edge
        if (fall_c) begin
            tdi_d = (state == S_SDR) && shift_q[0];
        end
        // ir_in holds the last scanned IR until the next UIR
        if (state == S_UIR) begin
            ir_in_d = ir_lat;
        end
    end

    // Tck timing counters and scan datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt  <= '0;
            phase_hi  <= 1'b0;
            bit_cnt   <= '0;
            rti_cnt   <= '0;
            ir_lat    <= '0;
            shift_q   <= '0;
            capture_q <= '0;
        end else if (accept_c) begin
            half_cnt <= '0;
            phase_hi <= 1'b0;
            bit_cnt  <= '0;
            rti_cnt  <= '0;
            ir_lat   <= cmd_ir;
            shift_q  <= cmd_dr;
        end else if (running_c) begin
            if (half_end_c) begin
                half_cnt <= '0;
                phase_hi <= !phase_hi;
            end else begin
                half_cnt <= half_cnt + HALF_CNT_W'(1);
            end
            if ((state == S_SDR) && sample_c) begin
                shift_q <= {1'b0, shift_q[DR_WIDTH-1:1]};
                for (int unsigned i = 0; i < DR_WIDTH; i++) begin
                    if (bit_cnt == BIT_CNT_W'(i)) begin
                        capture_q[i] <= vji_tdo;
                    end
                end
            end
            if ((state == S_SDR) && period_end_c) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if ((state == S_RTI) && period_end_c) begin
                rti_cnt <= rti_cnt + RTI_CNT_W'(1);
            end
        end else begin
            // tck parked low in IDLE/DONE so the next scan starts with a low phase
            half_cnt <= '0;
            phase_hi <= 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
        end else begin
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_dr     <= rsp_dr_d;
            rsp_ir_out <= rsp_ir_out_d;
            vji_tck    <= tck_d;
            vji_tdi    <= tdi_d;
            vji_ir_in  <= ir_in_d;
            vji_uir    <= uir_d;
            vji_cdr    <= cdr_d;
            vji_sdr    <= sdr_d;
            vji_udr    <= udr_d;
            vji_rti    <= rti_d;
        end
    end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// -----------------------------------------------------------------------------
// tb_cpu_debug_scan_master
// Drives cpu_debug_scan_master against a loopback model of the debug slave's
// 38-bit data register and checks responses, latency, strobe counts, reset
// abort, backpressure and back-to-back behaviour. A second instance covers the
// TCK_HALF=1 / RTI_TCKS=3 corner.
// -----------------------------------------------------------------------------
module tb_cpu_debug_scan_master;

    localparam int DR_W   = 38;
    localparam int IR_W   = 2;
    localparam int TH     = 2;
    localparam int RTI    = 1;
    localparam int TH_C   = 1;
    localparam int RTI_C  = 3;
    localparam int NPER   = 3 + DR_W + RTI;
    localparam int NPER_C = 3 + DR_W + RTI_C;
    localparam int LAT    = 1 + 2 * TH * NPER;
    localparam int LAT_C  = 1 + 2 * TH_C * NPER_C;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;
    logic            vji_tck, vji_tdi, vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic [IR_W-1:0] ir_out_drv;
    logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic            cmd_valid_c, cmd_ready_c, rsp_valid_c, rsp_ready_c;
    logic [IR_W-1:0] cmd_ir_c, rsp_ir_out_c, ir_in_c, ir_out_c;
    logic [DR_W-1:0] cmd_dr_c, rsp_dr_c;
    logic            tck_c, tdi_c, tdo_c, uir_c, cdr_c, sdr_c, udr_c, rti_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cpu_debug_scan_master #(.DR_WIDTH(DR_W), .IR_WIDTH(IR_W), .TCK_HALF(TH), .RTI_TCKS(RTI)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(ir_out_drv),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    cpu_debug_scan_master #(.DR_WIDTH(DR_W), .IR_WIDTH(IR_W), .TCK_HALF(TH_C), .RTI_TCKS(RTI_C)) dut_c (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c), .cmd_ir(cmd_ir_c), .cmd_dr(cmd_dr_c),
        .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready_c), .rsp_dr(rsp_dr_c), .rsp_ir_out(rsp_ir_out_c),
        .vji_tck(tck_c), .vji_tdi(tdi_c), .vji_tdo(tdo_c),
        .vji_ir_in(ir_in_c), .vji_ir_out(ir_out_c),
        .vji_uir(uir_c), .vji_cdr(cdr_c), .vji_sdr(sdr_c), .vji_udr(udr_c), .vji_rti(rti_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave data register model: load at CDR rise, shift in tdi on SDR rises
    logic [DR_W-1:0] slave_q;
    logic [DR_W-1:0] slave_pre;
    assign vji_tdo = slave_q[0];
    always @(posedge vji_tck) begin
        if (vji_cdr)      slave_q <= slave_pre;
        else if (vji_sdr) slave_q <= {vji_tdi, slave_q[DR_W-1:1]};
    end

    // Running counts of tck rises and of the strobe seen high at each rise
    int n_rise = 0, n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    always @(posedge vji_tck) begin
        n_rise <= n_rise + 1;
        if (vji_uir) n_uir <= n_uir + 1;
        if (vji_cdr) n_cdr <= n_cdr + 1;
        if (vji_sdr) n_sdr <= n_sdr + 1;
        if (vji_udr) n_udr <= n_udr + 1;
        if (vji_rti) n_rti <= n_rti + 1;
    end

    int n_rise_c = 0, n_rti_c = 0;
    always @(posedge tck_c) begin
        n_rise_c <= n_rise_c + 1;
        if (rti_c) n_rti_c <= n_rti_c + 1;
    end

    // Pin rules: one strobe at most, tdi low outside SDR, and strobes/tdi/ir_in
    // only move with a tck falling edge (or when starting from all-idle pins)
    logic [7:0] mon_prev = '0;
    logic [7:0] mon_cur;
    logic       mon_prev_tck = 1'b0;
    logic       mon_prev_rst = 1'b1;
    int         mon_v;
    int         viol = 0;
    always @(negedge clk) begin
        mon_cur = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi, vji_ir_in};
        mon_v = 0;
        if (!$onehot0(mon_cur[7:3])) mon_v++;
        if (vji_tdi && !vji_sdr) mon_v++;
        if (!reset && !mon_prev_rst && (mon_cur != mon_prev) &&
            !(!vji_tck && (mon_prev_tck || (mon_prev[7:3] == 5'b0)))) mon_v++;
        viol         <= viol + mon_v;
        mon_prev     <= mon_cur;
        mon_prev_tck <= vji_tck;
        mon_prev_rst <= reset;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic accept_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, output int k);
        int n;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        k = cyc;
        cmd_valid = 1'b0;
        check("accept_ready_low", cmd_ready, 1'b0);
    endtask

    task automatic wait_rsp(output int e);
        int n;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        e = cyc;
        check("rsp_valid_seen", rsp_valid, 1'b1);
    endtask

    task automatic do_scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [DR_W-1:0] pre, input logic [IR_W-1:0] irout, input int hold);
        int k, e, bad;
        int s_rise, s_uir, s_cdr, s_sdr, s_udr, s_rti;
        slave_pre  = pre;
        ir_out_drv = irout;
        rsp_ready  = (hold == 0);
        accept_cmd(ir, dr, k);
        s_rise = n_rise; s_uir = n_uir; s_cdr = n_cdr;
        s_sdr  = n_sdr;  s_udr = n_udr; s_rti = n_rti;
        wait_rsp(e);
        check("latency", e - k, LAT);
        check("rsp_dr", rsp_dr, pre);
        check("rsp_ir_out", rsp_ir_out, irout);
        check("slave_final", slave_q, dr);
        check("ir_in", vji_ir_in, ir);
        check("n_tck_rise", n_rise - s_rise, NPER);
        check("n_sdr", n_sdr - s_sdr, DR_W);
        check("n_uir_cdr_udr", {n_uir - s_uir, n_cdr - s_cdr, n_udr - s_udr}, {32'd1, 32'd1, 32'd1});
        check("n_rti", n_rti - s_rti, RTI);
        check("done_pins", {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 7'b0);
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                cmd_valid = (i == 5);
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_dr !== pre || cmd_ready !== 1'b0) bad++;
            end
            cmd_valid = 1'b0;
            check("backpressure_stable", bad, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_one_clk", rsp_valid, 1'b0);
        check("ready_after_rsp", cmd_ready, 1'b1);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("no_queued_cmd", cmd_ready, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, e, bad, n, s_sdr, prev;
        logic [DR_W-1:0] d1, p1, d2, p2;

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_dr = '0;
        ir_out_drv = '0; slave_pre = '0; slave_q = '0;
        cmd_valid_c = 1'b0; rsp_ready_c = 1'b0; cmd_ir_c = '0; cmd_dr_c = '0;
        ir_out_c = 2'd1; tdo_c = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_dr", rsp_dr, '0);
        check("reset_rsp_ir_out", rsp_ir_out, '0);
        check("reset_vji", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, '0);
        check("reset_corner_ready", cmd_ready_c, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Directed loopback, with 20 clk of response backpressure
        do_scan(2'd2, 38'h2A_5A5A_5A5A, 38'h15_A5A5_A5A5, 2'd3, 20);

        // Randomized scans
        for (int i = 0; i < 4; i++) begin
            do_scan(IR_W'($urandom()), DR_W'({$urandom(), $urandom()}), DR_W'({$urandom(), $urandom()}),
                    IR_W'($urandom()), (i % 2 == 0) ? 0 : int'($urandom_range(1, 6)));
        end

        // Reset in the middle of SDR bit 10
        slave_pre = DR_W'({$urandom(), $urandom()});
        ir_out_drv = 2'd1;
        rsp_ready = 1'b0;
        accept_cmd(2'd1, DR_W'({$urandom(), $urandom()}), k);
        s_sdr = n_sdr;
        n = 0;
        while ((n_sdr - s_sdr) < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_sdr_bit10", n_sdr - s_sdr, 10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_vji", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, '0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        check("abort_no_rsp", bad, 0);
        check("abort_rsp_dr", rsp_dr, '0);
        do_scan(2'd3, DR_W'({$urandom(), $urandom()}), DR_W'({$urandom(), $urandom()}), 2'd2, 0);

        // Back-to-back: cmd_valid held high, IR 0 then IR 3
        d1 = DR_W'({$urandom(), $urandom()}); p1 = DR_W'({$urandom(), $urandom()});
        d2 = DR_W'({$urandom(), $urandom()}); p2 = DR_W'({$urandom(), $urandom()});
        slave_pre = p1; ir_out_drv = 2'd1; rsp_ready = 1'b1;
        cmd_ir = 2'd0; cmd_dr = d1; cmd_valid = 1'b1;
        @(negedge clk);
        k = cyc;
        check("b2b_accept1", cmd_ready, 1'b0);
        wait_rsp(e);
        check("b2b_latency1", e - k, LAT);
        check("b2b_ir_out1", rsp_ir_out, 2'd1);
        check("b2b_dr1", rsp_dr, p1);
        cmd_ir = 2'd3; cmd_dr = d2; slave_pre = p2; ir_out_drv = 2'd2;
        @(negedge clk);
        check("b2b_rsp_one_clk", rsp_valid, 1'b0);
        check("b2b_ready_gap", cmd_ready, 1'b1);
        @(negedge clk);
        k = cyc;
        cmd_valid = 1'b0;
        check("b2b_accept2", cmd_ready, 1'b0);
        bad = 0;
        n = 0;
        while (!vji_uir && n < 20) begin
            if (vji_ir_in !== 2'd0) bad++;
            @(negedge clk);
            n++;
        end
        check("b2b_ir_in_held", bad, 0);
        check("b2b_ir_in_at_uir", {vji_uir, vji_ir_in}, {1'b1, 2'd3});
        wait_rsp(e);
        check("b2b_latency2", e - k, LAT);
        check("b2b_ir_out2", rsp_ir_out, 2'd2);
        check("b2b_dr2", rsp_dr, p2);
        check("b2b_slave2", slave_q, d2);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Corner instance: TCK_HALF=1, RTI_TCKS=3, tdo tied high
        cmd_ir_c = 2'd1; cmd_dr_c = DR_W'({$urandom(), $urandom()}); cmd_valid_c = 1'b1;
        @(negedge clk);
        k = cyc;
        cmd_valid_c = 1'b0;
        begin
            int s_r, s_t;
            s_r = n_rise_c; s_t = n_rti_c;
            @(negedge clk);
            prev = int'(tck_c);
            bad = 0;
            n = 0;
            while (!rsp_valid_c && n < 500) begin
                @(negedge clk);
                n++;
                if (int'(tck_c) == prev) bad++;
                prev = int'(tck_c);
            end
            check("corner_rsp_seen", rsp_valid_c, 1'b1);
            check("corner_latency", cyc - k, LAT_C);
            check("corner_tck_toggle", bad, 0);
            check("corner_n_rise", n_rise_c - s_r, NPER_C);
            check("corner_n_rti", n_rti_c - s_t, RTI_C);
            check("corner_rsp_dr", rsp_dr_c, {DR_W{1'b1}});
            check("corner_ir_out", rsp_ir_out_c, 2'd1);
        end
        rsp_ready_c = 1'b1;
        @(negedge clk);
        check("corner_rsp_one_clk", rsp_valid_c, 1'b0);
        rsp_ready_c = 1'b0;

        @(negedge clk);
        check("strobe_pin_rules", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
